// File: rtl/alu_control_mdu.sv
// Registered ALU control decoder plus multiply/divide sequencer with issue-stall interlock.
// Latency 1 for decode; o_stall combinational; div/divu support gated by ALU_CONTROL_MDU_DIV_EN.
module alu_control_mdu #(
    parameter int NB_ALU_CONTROL = 4,
    parameter int NB_ALU_OP      = 2,
    parameter int NB_INSTRUCCION = 6,
    parameter int MULT_LAT       = 4,
    parameter int DIV_LAT        = 32,
    parameter int NB_CNT         = 6
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    input  logic [NB_INSTRUCCION-1:0] i_inst_funcion,
    input  logic [NB_INSTRUCCION-1:0] i_opcode,
    input  logic [NB_ALU_OP-1:0]      i_alu_op,
    output logic [NB_ALU_CONTROL-1:0] o_alu_code,
    output logic                      o_valid,
    output logic                      o_stall,
    output logic                      o_mdu_start,
    output logic [1:0]                o_mdu_op,
    output logic                      o_hilo_wr,
    output logic                      o_illegal
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [NB_CNT-1:0] MULT_CNT = NB_CNT'(MULT_LAT - 1);
    localparam logic [NB_CNT-1:0] DIV_CNT  = NB_CNT'(DIV_LAT - 1);

    state_t                    state_q, state_d;
    logic [NB_CNT-1:0]         cnt_q, cnt_d;
    logic [NB_ALU_CONTROL-1:0] alu_code_q, alu_code_d;
    logic                      valid_q, valid_d;
    logic                      mdu_start_q, mdu_start_d;
    logic [1:0]                mdu_op_q, mdu_op_d;
    logic                      hilo_wr_q, hilo_wr_d;
    logic                      illegal_q, illegal_d;

    logic [3:0] dec;
    logic       is_mdu, is_div, is_mfhilo, mdu_ok, stall, capture;

    always_comb begin
        dec = 4'b0110;
        case (i_alu_op)
            2'b00: dec = 4'b0110;
            2'b01: dec = 4'b0111;
            2'b10: begin
                case (i_inst_funcion)
                    6'b000000, 6'b000100: dec = 4'b0000;
                    6'b000010, 6'b000110: dec = 4'b0001;
                    6'b000011, 6'b000111: dec = 4'b0010;
                    6'b100001:            dec = 4'b0110;
                    6'b100011:            dec = 4'b0111;
                    6'b100100:            dec = 4'b1000;
                    6'b100101:            dec = 4'b1001;
                    6'b100110:            dec = 4'b1010;
                    6'b100111:            dec = 4'b1011;
                    6'b101010:            dec = 4'b1100;
                    6'b101011:            dec = 4'b1101;
                    default:              dec = 4'b0110;
                endcase
            end
            default: begin
                case (i_opcode)
                    6'b001000: dec = 4'b0100;
                    6'b001100: dec = 4'b1000;
                    6'b001101: dec = 4'b1001;
                    6'b001110: dec = 4'b1010;
                    6'b001111: dec = 4'b0011;
                    6'b001010: dec = 4'b1100;
                    6'b001011: dec = 4'b1101;
                    default:   dec = 4'b1000;
                endcase
            end
        endcase
    end

    assign is_mdu    = (i_alu_op == 2'b10) && (i_inst_funcion[5:2] == 4'b0110);
    assign is_div    = is_mdu && i_inst_funcion[1];
    assign is_mfhilo = (i_alu_op == 2'b10) &&
                       ((i_inst_funcion == 6'b010000) || (i_inst_funcion == 6'b010010));
`ifdef ALU_CONTROL_MDU_DIV_EN
    assign mdu_ok = is_mdu;
`else
    assign mdu_ok = is_mdu && !is_div;
`endif

    // Stall only while BUSY; the completion cycle is already IDLE, so the held op captures then.
    assign stall   = i_valid && !i_rst && (state_q == BUSY) && (is_mdu || is_mfhilo);
    assign capture = i_valid && !stall;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_code_d  = alu_code_q;
        valid_d     = capture;
        mdu_start_d = 1'b0;
        mdu_op_d    = mdu_op_q;
        hilo_wr_d   = 1'b0;
        illegal_d   = capture && is_mdu && !mdu_ok;
        if (capture) begin
            alu_code_d = NB_ALU_CONTROL'(dec);
        end
        case (state_q)
            IDLE: begin
                if (capture && mdu_ok) begin
                    mdu_start_d = 1'b1;
                    mdu_op_d    = i_inst_funcion[1:0];
                    cnt_d       = is_div ? DIV_CNT : MULT_CNT;
                    state_d     = BUSY;
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    hilo_wr_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - NB_CNT'(1);
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_code_q  <= NB_ALU_CONTROL'(4'b0110);
            valid_q     <= 1'b0;
            mdu_start_q <= 1'b0;
            mdu_op_q    <= 2'b00;
            hilo_wr_q   <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_code_q  <= alu_code_d;
            valid_q     <= valid_d;
            mdu_start_q <= mdu_start_d;
            mdu_op_q    <= mdu_op_d;
            hilo_wr_q   <= hilo_wr_d;
            illegal_q   <= illegal_d;
        end
    end

    assign o_alu_code  = alu_code_q;
    assign o_valid     = valid_q;
    assign o_stall     = stall;
    assign o_mdu_start = mdu_start_q;
    assign o_mdu_op    = mdu_op_q;
    assign o_hilo_wr   = hilo_wr_q;
    assign o_illegal   = illegal_q;

endmodule

// File: tb/tb_alu_control_mdu.sv
// Directed bench for alu_control_mdu: decode table, MDU sequencing, stall interlock, reset.
module tb_alu_control_mdu;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_valid;
    logic [5:0] i_inst_funcion;
    logic [5:0] i_opcode;
    logic [1:0] i_alu_op;
    logic [3:0] o_alu_code;
    logic       o_valid, o_stall, o_mdu_start, o_hilo_wr, o_illegal;
    logic [1:0] o_mdu_op;

    int tests = 0;
    int failed = 0;
    int hilo_cnt;

    alu_control_mdu #(
        .NB_ALU_CONTROL(4), .NB_ALU_OP(2), .NB_INSTRUCCION(6),
        .MULT_LAT(4), .DIV_LAT(32), .NB_CNT(6)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid),
        .i_inst_funcion(i_inst_funcion), .i_opcode(i_opcode), .i_alu_op(i_alu_op),
        .o_alu_code(o_alu_code), .o_valid(o_valid), .o_stall(o_stall),
        .o_mdu_start(o_mdu_start), .o_mdu_op(o_mdu_op), .o_hilo_wr(o_hilo_wr),
        .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [5:0] opc);
        i_valid        = v;
        i_alu_op       = op;
        i_inst_funcion = fn;
        i_opcode       = opc;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_code"},    o_alu_code, 4'b0110);
        chk({tag, "_valid"},   o_valid, 0);
        chk({tag, "_start"},   o_mdu_start, 0);
        chk({tag, "_op"},      o_mdu_op, 0);
        chk({tag, "_hilo"},    o_hilo_wr, 0);
        chk({tag, "_illegal"}, o_illegal, 0);
    endtask

    logic [1:0] t_op  [12];
    logic [5:0] t_fn  [12];
    logic [5:0] t_opc [12];
    logic [3:0] t_exp [12];

    initial begin
        t_op  = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                  2'b11, 2'b11, 2'b11, 2'b10};
        t_fn  = '{6'd0, 6'd0, 6'b000100, 6'b000011, 6'b100011, 6'b100111, 6'b101011,
                  6'b111111, 6'd0, 6'd0, 6'd0, 6'b000110};
        t_opc = '{6'b100011, 6'b000100, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0,
                  6'b001111, 6'b001010, 6'b000100, 6'd0};
        t_exp = '{4'b0110, 4'b0111, 4'b0000, 4'b0010, 4'b0111, 4'b1011, 4'b1101,
                  4'b0110, 4'b0011, 4'b1100, 4'b1000, 4'b0001};

        // Reset
        i_rst = 1'b1;
        drive(0, 2'b00, 6'd0, 6'd0);
        repeat (2) tick();
        chk_reset_vals("reset");
        chk("reset_stall", o_stall, 0);
        i_rst = 1'b0;

        // Basic decode
        drive(1, 2'b10, 6'b100001, 6'd0);
        tick();
        chk("addu_valid", o_valid, 1);
        chk("addu_code", o_alu_code, 4'b0110);
        drive(1, 2'b11, 6'd0, 6'b001011);
        tick();
        chk("sltiu_code", o_alu_code, 4'b1101);
        for (int i = 0; i < 12; i++) begin
            drive(1, t_op[i], t_fn[i], t_opc[i]);
            tick();
            chk($sformatf("table%0d_code", i), o_alu_code, t_exp[i]);
            chk($sformatf("table%0d_valid", i), o_valid, 1);
        end
        drive(0, 2'b10, 6'b100110, 6'd0);
        tick();
        chk("novalid_valid", o_valid, 0);
        chk("novalid_hold", o_alu_code, 4'b0001);

        // multu with an unrelated addu issued mid-busy
        drive(1, 2'b10, 6'b011001, 6'd0);
        #1 chk("multu_issue_stall", o_stall, 0);
        tick();
        chk("multu_start", o_mdu_start, 1);
        chk("multu_op", o_mdu_op, 2'b01);
        chk("multu_code", o_alu_code, 4'b0110);
        drive(1, 2'b10, 6'b100001, 6'd0);
        #1 chk("addu_busy_stall", o_stall, 0);
        tick();
        chk("addu_busy_valid", o_valid, 1);
        chk("multu_start_pulse", o_mdu_start, 0);
        drive(0, 2'b00, 6'd0, 6'd0);
        for (int c = 3; c <= 4; c++) begin
            tick();
            chk($sformatf("multu_hilo_c%0d", c), o_hilo_wr, 0);
        end
        tick();
        chk("multu_hilo_c5", o_hilo_wr, 1);
        tick();
        chk("multu_hilo_pulse", o_hilo_wr, 0);

        // mult followed by mflo one cycle after the start pulse
        drive(1, 2'b10, 6'b011000, 6'd0);
        tick();
        chk("mult_start", o_mdu_start, 1);
        chk("mult_op", o_mdu_op, 2'b00);
        drive(1, 2'b10, 6'b010010, 6'd0);
        #1 chk("mflo_stall_c1", o_stall, 1);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk($sformatf("mflo_stall_c%0d", c), o_stall, 1);
            chk($sformatf("mflo_valid_c%0d", c), o_valid, 0);
        end
        tick();
        chk("mflo_hilo", o_hilo_wr, 1);
        chk("mflo_release", o_stall, 0);
        chk("mflo_valid_c5", o_valid, 0);
        tick();
        chk("mflo_captured", o_valid, 1);
        chk("mflo_code", o_alu_code, 4'b0110);
        drive(0, 2'b00, 6'd0, 6'd0);
        tick();
        chk("mflo_no_dup", o_valid, 0);

`ifdef ALU_CONTROL_MDU_DIV_EN
        // mult then div back-to-back: div waits for mult completion
        drive(1, 2'b10, 6'b011000, 6'd0);
        tick();
        chk("m2_start", o_mdu_start, 1);
        drive(1, 2'b10, 6'b011010, 6'd0);
        #1 chk("div_stall_c1", o_stall, 1);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk($sformatf("div_stall_c%0d", c), o_stall, 1);
        end
        tick();
        chk("m2_hilo", o_hilo_wr, 1);
        chk("div_release", o_stall, 0);
        tick();
        chk("div_start", o_mdu_start, 1);
        chk("div_op", o_mdu_op, 2'b10);
        chk("div_valid", o_valid, 1);
        drive(0, 2'b00, 6'd0, 6'd0);
        hilo_cnt = 0;
        for (int c = 0; c < 31; c++) begin
            tick();
            hilo_cnt += int'(o_hilo_wr);
        end
        chk("div_early_hilo", hilo_cnt, 0);
        tick();
        chk("div_hilo_32", o_hilo_wr, 1);
        tick();
        drive(1, 2'b10, 6'b011010, 6'd0);
`else
        // div without divider support is flagged illegal
        drive(1, 2'b10, 6'b011010, 6'd0);
        #1 chk("div_issue_stall", o_stall, 0);
        tick();
        chk("div_illegal", o_illegal, 1);
        chk("div_no_start", o_mdu_start, 0);
        chk("div_valid", o_valid, 1);
        chk("div_op_kept", o_mdu_op, 2'b00);
        drive(0, 2'b00, 6'd0, 6'd0);
        #1 chk("div_after_stall", o_stall, 0);
        tick();
        chk("div_illegal_pulse", o_illegal, 0);
        chk("div_still_no_start", o_mdu_start, 0);
        drive(1, 2'b10, 6'b011001, 6'd0);
`endif

        // Reset two cycles into an MDU operation
        tick();
        chk("rst_op_start", o_mdu_start, 1);
        drive(0, 2'b00, 6'd0, 6'd0);
        tick();
        i_rst = 1'b1;
        drive(1, 2'b10, 6'b010010, 6'd0);
        #1 chk("rst_stall_drop", o_stall, 0);
        tick();
        chk_reset_vals("rst_mid");
        i_rst = 1'b0;
        drive(0, 2'b00, 6'd0, 6'd0);
        hilo_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            hilo_cnt += int'(o_hilo_wr);
        end
        chk("rst_no_hilo", hilo_cnt, 0);
        drive(1, 2'b10, 6'b010010, 6'd0);
        #1 chk("rst_idle_stall", o_stall, 0);
        tick();
        chk("rst_idle_valid", o_valid, 1);
        drive(0, 2'b00, 6'd0, 6'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
